vblank_update_scheduler: RTL and testbench



---
 rtl/vga_pkg.sv | 12 +
 rtl/vblank_update_scheduler_rr_pick.sv | 38 +++
 rtl/vblank_update_scheduler.sv | 134 +++++++++++++
 tb/tb_vblank_update_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Definitions shared by the frame-timing and update-scheduling blocks.
package vga_pkg;

  localparam int POS_W_DEF   = 12;
  localparam int FRAME_W_DEF = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SNAP = 2'd1;
  localparam logic [1:0] ST_ARB  = 2'd2;
  localparam logic [1:0] ST_WAIT = 2'd3;

endpackage

// File: rtl/vblank_update_scheduler_rr_pick.sv
// Combinational round-robin picker: first set bit of pending at or after
// rr_ptr, searching cyclically.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  pending,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] index,
  output logic          any
);

  logic [2*N-1:0] doubled;
  logic [N-1:0]   rotated;
  logic [IW-1:0]  offset;
  logic [IW:0]    sum;

  // NOTE: every output of a combinational block gets a default first so
  // no path through it leaves a value held, which would infer a latch.
  always_comb begin
    doubled = {pending, pending} >> rr_ptr;
    rotated = doubled[N-1:0];
    any     = |pending;
    offset  = '0;
    // Descending scan: the lowest set offset is written last and wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (rotated[k]) offset = IW'(k);
    end
    sum   = {1'b0, rr_ptr} + {1'b0, offset};
    index = (sum >= (IW + 1)'(N)) ? IW'(sum - (IW + 1)'(N)) : sum[IW-1:0];
    onehot = '0;
    for (int k = 0; k < N; k++) begin
      onehot[k] = any && (index == IW'(k));
    end
  end

endmodule

// File: rtl/vblank_update_scheduler.sv
// Grants a shared state-update slot to each requesting engine in turn, only
// while vertical blanking is active, and latches mouse position per frame.
module vblank_update_scheduler
  import vga_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int POS_W    = POS_W_DEF,
  parameter int SLOT_MAX = 1024,
  parameter int FRAME_W  = FRAME_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vblnk,
  input  logic [POS_W-1:0]   xpos,
  input  logic [POS_W-1:0]   ypos,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   done,
  output logic [N_REQ-1:0]   grant,
  output logic [POS_W-1:0]   xpos_frame,
  output logic [POS_W-1:0]   ypos_frame,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               busy,
  output logic               overrun,
  output logic [N_REQ-1:0]   timeout_err
);

  localparam int IW = $clog2(N_REQ);
  localparam int SW = $clog2(SLOT_MAX);

  logic [1:0]       state;
  logic             vblnk_q;
  logic [N_REQ-1:0] pending;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    g_idx;
  logic [IW-1:0]    first_idx;
  logic             first_vld;
  logic [SW-1:0]    slot_cnt;

  logic             vblnk_rise;
  logic             vblnk_fall;
  logic             g_done;
  logic             slot_last;
  logic [N_REQ-1:0] pick_onehot;
  logic [IW-1:0]    pick_index;
  logic             pick_any;

  assign vblnk_rise = vblnk & ~vblnk_q;
  assign vblnk_fall = ~vblnk & vblnk_q;
  assign g_done     = done[g_idx];
  assign slot_last  = (slot_cnt == SW'(SLOT_MAX - 1));
  assign busy       = (state != ST_IDLE);

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .onehot  (pick_onehot),
    .index   (pick_index),
    .any     (pick_any)
  );

  // NOTE: state is written only with non-blocking assignments so every
  // read in this block sees the pre-edge value; reset is synchronous.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      vblnk_q     <= 1'b1;
      pending     <= '0;
      rr_ptr      <= '0;
      g_idx       <= '0;
      first_idx   <= '0;
      first_vld   <= 1'b0;
      slot_cnt    <= '0;
      grant       <= '0;
      xpos_frame  <= '0;
      ypos_frame  <= '0;
      frame_cnt   <= '0;
      overrun     <= 1'b0;
      timeout_err <= '0;
    end else begin
      vblnk_q <= vblnk;
      overrun <= 1'b0;

      // Frame-start bookkeeping happens even if blanking ends in this cycle.
      if (state == ST_SNAP) begin
        xpos_frame  <= xpos;
        ypos_frame  <= ypos;
        frame_cnt   <= frame_cnt + 1'b1;
        timeout_err <= '0;
        first_vld   <= 1'b0;
        if (first_vld)
          rr_ptr <= (first_idx == IW'(N_REQ - 1)) ? '0 : first_idx + 1'b1;
      end

      if (vblnk_fall && busy) begin
        grant   <= '0;
        overrun <= |pending;
        pending <= '0;
        state   <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (vblnk_rise) state <= ST_SNAP;
          ST_SNAP: begin
            pending <= req;
            state   <= ST_ARB;
          end
          ST_ARB: begin
            if (!pick_any) begin
              state <= ST_IDLE;
            end else begin
              grant    <= pick_onehot;
              g_idx    <= pick_index;
              slot_cnt <= '0;
              state    <= ST_WAIT;
              if (!first_vld) begin
                first_idx <= pick_index;
                first_vld <= 1'b1;
              end
            end
          end
          default: begin
            slot_cnt <= slot_cnt + 1'b1;
            if (g_done || slot_last) begin
              grant          <= '0;
              pending[g_idx] <= 1'b0;
              state          <= ST_ARB;
              if (!g_done) timeout_err[g_idx] <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vblank_update_scheduler.sv
// Self-checking bench: each frame's grant schedule is derived from the
// snapshot, rotation pointer and per-requester latencies, then replayed.
module tb_vblank_update_scheduler;

  localparam int N_REQ    = 4;
  localparam int POS_W    = 12;
  localparam int SLOT_MAX = 64;
  localparam int FRAME_W  = 16;
  localparam int MAXLEN   = 1024;
  localparam int NEVER    = 1000;

  logic               clk;
  logic               rst_n;
  logic               vblnk;
  logic [POS_W-1:0]   xpos;
  logic [POS_W-1:0]   ypos;
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   done;
  logic [N_REQ-1:0]   grant;
  logic [POS_W-1:0]   xpos_frame;
  logic [POS_W-1:0]   ypos_frame;
  logic [FRAME_W-1:0] frame_cnt;
  logic               busy;
  logic               overrun;
  logic [N_REQ-1:0]   timeout_err;

  vblank_update_scheduler #(
    .N_REQ(N_REQ), .POS_W(POS_W), .SLOT_MAX(SLOT_MAX), .FRAME_W(FRAME_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vblnk(vblnk), .xpos(xpos), .ypos(ypos),
    .req(req), .done(done), .grant(grant), .xpos_frame(xpos_frame),
    .ypos_frame(ypos_frame), .frame_cnt(frame_cnt), .busy(busy),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int fr_id = 0;

  // Reference state carried between frames.
  logic [FRAME_W-1:0] m_fc;
  int                 m_rr;
  logic [N_REQ-1:0]   m_to;
  logic [POS_W-1:0]   m_xf;
  logic [POS_W-1:0]   m_yf;
  int                 lat_cfg [N_REQ];

  // Expected values after each edge of the current frame, and done stimulus.
  logic [N_REQ-1:0] e_grant   [MAXLEN];
  logic [N_REQ-1:0] e_to      [MAXLEN];
  logic [N_REQ-1:0] done_plan [MAXLEN];
  bit               e_busy    [MAXLEN];
  bit               e_ovr     [MAXLEN];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s (frame %0d): observed=%0h expected=%0h", tag, fr_id, obs, exp);
    end
  endtask

  task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
    lat_cfg[0] = l0; lat_cfg[1] = l1; lat_cfg[2] = l2; lat_cfg[3] = l3;
  endtask

  // Frame layout: edge 0 vblnk low, vblnk high on edges 1..v, low after.
  // Rise seen at edge 1, snapshot at edge 2, first arbitration at edge 3.
  task automatic run_frame(input int v, input logic [N_REQ-1:0] snap_req,
                           input logic [POS_W-1:0] xs, input logic [POS_W-1:0] ys,
                           input bit strays, input logic [N_REQ-1:0] stray_fixed);
    int len, a, f, g, x, lim, first, end_e;
    logic [N_REQ-1:0] pend, oh;
    logic [FRAME_W-1:0] fc_next;
    bit stop;
    len = v + 6;
    for (int e = 0; e < len; e++) begin
      e_grant[e]   = '0;
      e_busy[e]    = 1'b0;
      e_ovr[e]     = 1'b0;
      e_to[e]      = (e >= 2) ? '0 : m_to;
      done_plan[e] = '0;
    end
    pend  = snap_req;
    a     = 3;
    f     = v + 1;
    first = -1;
    end_e = 0;
    stop  = 1'b0;
    if (f == 2) begin
      end_e = 2;
      stop  = 1'b1;
    end
    while (!stop) begin
      if (f == a) begin
        e_ovr[f] = (pend != 0);
        end_e    = f;
        stop     = 1'b1;
      end else if (pend == 0) begin
        end_e = a;
        stop  = 1'b1;
      end else begin
        g = m_rr;
        while (((pend >> g) & 4'd1) == 0) g = (g + 1) % N_REQ;
        oh = 4'd1 << g;
        if (first < 0) first = g;
        lim = (lat_cfg[g] < SLOT_MAX) ? lat_cfg[g] : SLOT_MAX;
        x   = a + lim;
        if (lat_cfg[g] <= SLOT_MAX && a + lat_cfg[g] <= f)
          done_plan[a + lat_cfg[g]] |= oh;
        if (f <= x) begin
          for (int e = a; e < f; e++) e_grant[e] = oh;
          e_ovr[f] = 1'b1;
          end_e    = f;
          stop     = 1'b1;
        end else begin
          for (int e = a; e < x; e++) e_grant[e] = oh;
          pend &= ~oh;
          if (lat_cfg[g] > SLOT_MAX)
            for (int e = x; e < len; e++) e_to[e] |= oh;
          a = x + 1;
        end
      end
    end
    for (int e = 1; e < end_e; e++) e_busy[e] = 1'b1;
    for (int e = 1; e < len; e++) begin
      logic [N_REQ-1:0] s;
      s = stray_fixed;
      if (strays) s |= 4'($urandom & $urandom);
      done_plan[e] |= s & ~e_grant[e-1];
    end

    fc_next = m_fc + 1'b1;
    for (int e = 0; e < len; e++) begin
      vblnk = (e >= 1 && e <= v);
      req   = (e == 2) ? snap_req : 4'($urandom);
      xpos  = (e <= 2) ? xs : 12'($urandom);
      ypos  = (e <= 2) ? ys : 12'($urandom);
      done  = done_plan[e];
      @(posedge clk);
      #1;
      check("grant", grant, e_grant[e]);
      check("busy", busy, e_busy[e]);
      check("overrun", overrun, e_ovr[e]);
      check("timeout_err", timeout_err, e_to[e]);
      check("frame_cnt", frame_cnt, (e >= 2) ? fc_next : m_fc);
      check("xpos_frame", xpos_frame, (e >= 2) ? xs : m_xf);
      check("ypos_frame", ypos_frame, (e >= 2) ? ys : m_yf);
    end
    done = '0;

    m_fc = fc_next;
    m_xf = xs;
    m_yf = ys;
    m_to = e_to[len-1];
    if (first >= 0) m_rr = (first + 1) % N_REQ;
    fr_id++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_to"}, timeout_err, 0);
    check({tag, "_fc"}, frame_cnt, 0);
    check({tag, "_xf"}, xpos_frame, 0);
    check({tag, "_yf"}, ypos_frame, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    m_fc = '0; m_rr = 0; m_to = '0; m_xf = '0; m_yf = '0;
    rst_n = 1'b0; vblnk = 1'b1; req = '0; done = '0; xpos = '0; ypos = '0;

    // Reset held with vblnk high, released at cycle 10: no frame start.
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      check_reset_outputs("release_in_blank");
    end
    vblnk = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_reset_outputs("first_fall");
    end

    // Basic frame, done five cycles after each grant.
    set_lat(5, 5, 5, 5);
    run_frame(40, 4'b0101, 12'd300, 12'd200, 1'b0, 4'b0000);
    check("basic_xf", xpos_frame, 300);
    check("basic_yf", ypos_frame, 200);
    check("basic_fc", frame_cnt, 1);

    // Rotation across three fully requested frames with immediate done.
    set_lat(1, 1, 1, 1);
    repeat (3) run_frame(30, 4'b1111, 12'($urandom), 12'($urandom), 1'b0, 4'b0000);

    // Timeout, then a frame where requester 0 hangs past the fall.
    set_lat(NEVER, NEVER, NEVER, NEVER);
    run_frame(100, 4'b0010, 12'd5, 12'd6, 1'b0, 4'b0000);
    set_lat(NEVER, 1, 1, 1);
    run_frame(50, 4'b0011, 12'd7, 12'd8, 1'b0, 4'b0000);

    // Stray done on a non-granted bit, then done coinciding with the fall.
    set_lat(8, 8, 8, 8);
    run_frame(40, 4'b0001, 12'd9, 12'd10, 1'b0, 4'b1000);
    set_lat(5, 5, 5, 5);
    run_frame(7, 4'b0001, 12'd11, 12'd12, 1'b0, 4'b0000);

    // Randomized frames.
    for (int i = 0; i < 25; i++) begin
      for (int r = 0; r < N_REQ; r++) begin
        if ($urandom_range(0, 5) == 0)       lat_cfg[r] = NEVER;
        else if ($urandom_range(0, 15) == 0) lat_cfg[r] = SLOT_MAX;
        else                                 lat_cfg[r] = $urandom_range(1, 12);
      end
      run_frame($urandom_range(3, 220), 4'($urandom), 12'($urandom), 12'($urandom),
                1'b1, 4'b0000);
    end

    // Reset asserted while a grant is held.
    vblnk = 1'b1; req = 4'b0001; done = '0;
    repeat (6) @(posedge clk);
    #1;
    check("mid_wait_grant", grant, 4'b0001);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_wait_reset");
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      check_reset_outputs("mid_wait_release");
    end
    vblnk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_fc = '0; m_rr = 0; m_to = '0; m_xf = '0; m_yf = '0;
    set_lat(3, 4, NEVER, 2);
    run_frame(30, 4'b1010, 12'd77, 12'd88, 1'b1, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
